sfu_pair_dispatch: RTL and testbench
====================================

// Module: sfu_pair_dispatch
// PURPOSE
//  Consumer end of the sfu_check interface: accepts the checked sample pair
//  (x_0/x_1, labels, flag_same_sfu) and issues it to the two SFU lanes.
//  Non-conflicting pairs issue in one beat; pairs flagged same-SFU are split
//  into two beats (lane 0 first, then lane 1) so one SFU never gets two samples
//  in one cycle. Registered output stage with valid/ready backpressure.
// PARAMETERS
//  DATA_WIDTH   8   sample width
//  LABEL_WIDTH  4   antenna label width (16 antennas)
//  CNT_WIDTH    16  width of saturating split-event counter
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            asynchronous reset, active-high
//  x_valid        in   1            input pair valid
//  x_ready        out  1            pair accepted when x_valid && x_ready
//  x_0, x_1       in   DATA_WIDTH   input samples
//  x_label_0/1    in   LABEL_WIDTH  labels of x_0 / x_1
//  flag_same_sfu  in   1            pair targets same SFU; sampled only on accept
//  y_ready        in   1            downstream accepts current output beat
//  y_0, y_1       out  DATA_WIDTH   lane 0 / lane 1 samples
//  y_label_0/1    out  LABEL_WIDTH  lane 0 / lane 1 labels
//  y_valid_0/1    out  1            lane 0 / lane 1 beat valid
//  split_cnt      out  CNT_WIDTH    number of split pairs, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0, FSM=PASS, hold regs 0. x_ready
//    reads 1 after reset. Reset mid-split discards the held sample.
//  - Output beat occupied = y_valid_0 | y_valid_1. Beat retires on a clk edge
//    with y_ready=1. Unoccupied beat is always retired.
//  - Output regs hold their values while occupied && !y_ready (no change on
//    stall). When a beat retires with nothing new to load: y_valid_* -> 0,
//    data/labels keep their last value.
//  - x_ready = (state==PASS) && (!occupied || y_ready). Combinational; it
//    does not depend on x_valid.
//  - FSM PASS, accept && !flag_same_sfu: on the next edge y_0/y_1/labels <=
//    inputs, y_valid_0=y_valid_1=1. Latency 1. Stay in PASS.
//  - FSM PASS, accept && flag_same_sfu: on the next edge y_0/y_label_0 <=
//    x_0/x_label_0, y_valid_0=1, y_valid_1=0. Hold reg <= x_1/x_label_1.
//    split_cnt += 1, saturating at all-ones. Go to SPLIT.
//  - FSM SPLIT: x_ready=0 and inputs are ignored. On an edge with y_ready=1,
//    y_1/y_label_1 <= hold reg, y_valid_1=1, y_valid_0=0. Go to PASS.
//  - A split pair occupies two output beats. Back-to-back non-conflict pairs
//    sustain one pair per cycle when y_ready=1.
//  - x_valid with no accept (x_ready=0) is ignored. The upstream must hold
//    the pair until it is accepted.
//  - Label values are passed through unmodified. flag_same_sfu is trusted;
//    labels are not compared here.
// TESTING
//  1 Reset: assert rst async mid-cycle -> all outputs 0 immediately.
//    After release: x_ready=1, split_cnt=0.
//  2 No conflict: x_0=8'h11, x_1=8'h22, labels 3/7, flag=0, y_ready=1 ->
//    next cycle y_0=11, y_1=22, both valid. Next cycle both valid=0.
//  3 Conflict: x_0=8'hA5, x_1=8'h5A, labels 4/4, flag=1, y_ready=1 ->
//    cycle+1: y_0=A5, only y_valid_0=1, x_ready=0.
//    cycle+2: y_1=5A, only y_valid_1=1.
//    split_cnt=1. x_ready=1 again at cycle+2.
//  4 Backpressure: hold y_ready=0 for 3 cycles during the SPLIT first beat
//    -> y_0/y_valid_0 stable, x_ready=0. Second beat appears the cycle after
//    y_ready=1.
//  5 Streaming: 8 consecutive pairs, alternating flag 0/1, y_ready=1 ->
//    12 output beats in order, no sample lost or duplicated, split_cnt=4.
//  6 Saturation/reset mid-op: with CNT_WIDTH=2, send 5 split pairs ->
//    split_cnt=3. Then assert rst while in SPLIT -> held sample dropped,
//    y_valid_*=0, state PASS.

Source files
------------

// File: rtl/sfu_pair_dispatch.sv
// sfu_pair_dispatch: consumer end of the sfu_check interface.
// Takes a checked sample pair and issues it to two SFU lanes through one
// registered output stage. A pair flagged as targeting the same SFU is split
// into two beats, lane 0 first and lane 1 second, so that no SFU receives two
// samples in the same cycle. The stage uses valid/ready backpressure.
module sfu_pair_dispatch #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [DATA_WIDTH-1:0]  x_0,
  input  logic [DATA_WIDTH-1:0]  x_1,
  input  logic [LABEL_WIDTH-1:0] x_label_0,
  input  logic [LABEL_WIDTH-1:0] x_label_1,
  input  logic                   flag_same_sfu,
  input  logic                   y_ready,
  output logic [DATA_WIDTH-1:0]  y_0,
  output logic [DATA_WIDTH-1:0]  y_1,
  output logic [LABEL_WIDTH-1:0] y_label_0,
  output logic [LABEL_WIDTH-1:0] y_label_1,
  output logic                   y_valid_0,
  output logic                   y_valid_1,
  output logic [CNT_WIDTH-1:0]   split_cnt
);

  typedef enum logic {PASS = 1'b0, SPLIT = 1'b1} state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  y_0_q, y_1_q;
  logic [LABEL_WIDTH-1:0] y_label_0_q, y_label_1_q;
  logic                   y_valid_0_q, y_valid_1_q;
  logic [DATA_WIDTH-1:0]  hold_data_q;
  logic [LABEL_WIDTH-1:0] hold_label_q;
  logic [CNT_WIDTH-1:0]   split_cnt_q, split_cnt_d;

  logic occupied;
  logic retire;
  logic accept;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // The output beat frees up when it is empty or when downstream takes it.
  // An empty beat always counts as freeing up, so a beat that was never
  // occupied never holds off the next load.
  assign occupied    = y_valid_0_q | y_valid_1_q;
  assign retire      = !occupied || y_ready;
  assign x_ready     = (state_q == PASS) && retire;
  assign accept      = x_valid && x_ready;
  assign split_cnt_d = sat_inc(split_cnt_q);

  // Dispatch FSM together with the registered output beat and the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PASS;
      y_0_q        <= '0;
      y_1_q        <= '0;
      y_label_0_q  <= '0;
      y_label_1_q  <= '0;
      y_valid_0_q  <= 1'b0;
      y_valid_1_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_label_q <= '0;
      split_cnt_q  <= '0;
    end else if (state_q == PASS) begin
      if (accept) begin
        y_0_q       <= x_0;
        y_label_0_q <= x_label_0;
        y_valid_0_q <= 1'b1;
        if (flag_same_sfu) begin
          // Lane 0 goes out now. Lane 1 waits in the hold register for the next beat.
          y_valid_1_q  <= 1'b0;
          hold_data_q  <= x_1;
          hold_label_q <= x_label_1;
          split_cnt_q  <= split_cnt_d;
          state_q      <= SPLIT;
        end else begin
          y_1_q       <= x_1;
          y_label_1_q <= x_label_1;
          y_valid_1_q <= 1'b1;
        end
      end else if (retire) begin
        // Nothing new to load. Drop the valids and keep data/labels as they were.
        y_valid_0_q <= 1'b0;
        y_valid_1_q <= 1'b0;
      end
    end else begin
      // SPLIT: the lane-0 beat is always occupied here, so it advances only on y_ready.
      if (y_ready) begin
        y_1_q       <= hold_data_q;
        y_label_1_q <= hold_label_q;
        y_valid_0_q <= 1'b0;
        y_valid_1_q <= 1'b1;
        state_q     <= PASS;
      end
    end
  end

  assign y_0       = y_0_q;
  assign y_1       = y_1_q;
  assign y_label_0 = y_label_0_q;
  assign y_label_1 = y_label_1_q;
  assign y_valid_0 = y_valid_0_q;
  assign y_valid_1 = y_valid_1_q;
  assign split_cnt = split_cnt_q;

endmodule

// File: tb/tb_sfu_pair_dispatch.sv
// Bench for sfu_pair_dispatch. Each accepted pair is expanded into its expected
// output beats and queued. A monitor retires beats against that queue.
// A second instance with a 2-bit counter shares the same stimulus.
module tb_sfu_pair_dispatch;

  logic       clk;
  logic       rst;
  logic       x_valid;
  logic [7:0] x_0, x_1;
  logic [3:0] x_label_0, x_label_1;
  logic       flag_same_sfu;
  logic       y_ready;

  logic        x_ready, y_valid_0, y_valid_1;
  logic [7:0]  y_0, y_1;
  logic [3:0]  y_label_0, y_label_1;
  logic [15:0] split_cnt;

  logic        s_x_ready, s_y_valid_0, s_y_valid_1;
  logic [7:0]  s_y_0, s_y_1;
  logic [3:0]  s_y_label_0, s_y_label_1;
  logic [1:0]  s_split_cnt;

  sfu_pair_dispatch #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready),
    .x_0(x_0), .x_1(x_1), .x_label_0(x_label_0), .x_label_1(x_label_1),
    .flag_same_sfu(flag_same_sfu), .y_ready(y_ready),
    .y_0(y_0), .y_1(y_1), .y_label_0(y_label_0), .y_label_1(y_label_1),
    .y_valid_0(y_valid_0), .y_valid_1(y_valid_1), .split_cnt(split_cnt)
  );

  sfu_pair_dispatch #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(s_x_ready),
    .x_0(x_0), .x_1(x_1), .x_label_0(x_label_0), .x_label_1(x_label_1),
    .flag_same_sfu(flag_same_sfu), .y_ready(y_ready),
    .y_0(s_y_0), .y_1(s_y_1), .y_label_0(s_y_label_0), .y_label_1(s_y_label_1),
    .y_valid_0(s_y_valid_0), .y_valid_1(s_y_valid_1), .split_cnt(s_split_cnt)
  );

  typedef struct {
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [3:0] l0, l1;
  } beat_t;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    n_splits   = 0;
  int    beats_seen = 0;
  logic  rand_yr    = 1'b0;
  logic  yr_force   = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single owner of y_ready: either random or the value the main sequence asks for.
  initial begin
    y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      y_ready = rand_yr ? 1'($urandom_range(0, 1)) : yr_force;
    end
  end

  // Monitor: a beat that will retire at the coming edge is compared and popped.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (y_valid_0 || y_valid_1) && y_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {y_valid_1, y_valid_0}, 32'h0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          beats_seen++;
          chk("beat_valids", {30'd0, y_valid_1, y_valid_0}, {30'd0, e.v1, e.v0});
          if (e.v0) chk("lane0", {y_label_0, y_0}, {e.l0, e.d0});
          if (e.v1) chk("lane1", {y_label_1, y_1}, {e.l1, e.d1});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a pair and hold it until it is accepted. Returns 2 time units after the accept edge.
  task automatic send_pair(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [3:0] l0, input logic [3:0] l1, input logic f);
    bit done;
    beat_t b;
    done = 0;
    x_valid = 1'b1; x_0 = d0; x_1 = d1; x_label_0 = l0; x_label_1 = l1; flag_same_sfu = f;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (x_ready) begin
        if (f) begin
          b = '{v0: 1'b1, v1: 1'b0, d0: d0, d1: 8'h0, l0: l0, l1: 4'h0};
          exp_q.push_back(b);
          b = '{v0: 1'b0, v1: 1'b1, d0: 8'h0, d1: d1, l0: 4'h0, l1: l1};
          exp_q.push_back(b);
          n_splits++;
        end else begin
          b = '{v0: 1'b1, v1: 1'b1, d0: d0, d1: d1, l0: l0, l1: l1};
          exp_q.push_back(b);
        end
        done = 1;
      end
      step();
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    x_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
    step();
    step();
  endtask

  // Mid-cycle asynchronous reset. Outputs must clear before any clock edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    exp_q.delete();
    n_splits = 0;
    #1;
    chk("rst_valids", {y_valid_1, y_valid_0, s_y_valid_1, s_y_valid_0}, 32'h0);
    chk("rst_data", {y_1, y_0, y_label_1, y_label_0}, 32'h0);
    chk("rst_sat_data", {s_y_1, s_y_0, s_y_label_1, s_y_label_0}, 32'h0);
    chk("rst_cnt", {split_cnt, 14'd0, s_split_cnt}, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] hold_y0;
    int cnt0, beats0, exp_sat;
    rst = 1'b1;
    x_valid = 1'b0; x_0 = '0; x_1 = '0; x_label_0 = '0; x_label_1 = '0; flag_same_sfu = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_x_ready", {31'd0, x_ready}, 32'd1);
    chk("post_rst_split_cnt", split_cnt, 32'd0);
    chk("post_rst_valids", {y_valid_1, y_valid_0}, 32'd0);

    // No-conflict pair: both lanes in one beat, and the beat empties one cycle later.
    send_pair(8'h11, 8'h22, 4'd3, 4'd7, 1'b0);
    chk("nc_data", {y_1, y_0}, 32'h2211);
    chk("nc_labels", {y_label_1, y_label_0}, 32'h73);
    chk("nc_valids", {y_valid_1, y_valid_0}, 32'h3);
    step();
    chk("nc_retired", {y_valid_1, y_valid_0}, 32'h0);

    // Conflict pair: lane 0 goes out first, then lane 1.
    send_pair(8'hA5, 8'h5A, 4'd4, 4'd4, 1'b1);
    chk("c1_y0", y_0, 32'hA5);
    chk("c1_valids", {y_valid_1, y_valid_0}, 32'h1);
    chk("c1_x_ready", {31'd0, x_ready}, 32'd0);
    step();
    chk("c2_y1", {y_label_1, y_1}, 32'h45A);
    chk("c2_valids", {y_valid_1, y_valid_0}, 32'h2);
    chk("c2_x_ready", {31'd0, x_ready}, 32'd1);
    chk("c2_split_cnt", split_cnt, 32'd1);
    step();

    // Backpressure held during the first beat of a split.
    yr_force = 1'b0;
    step();
    send_pair(8'h3C, 8'hC3, 4'd9, 4'd9, 1'b1);
    hold_y0 = y_0;
    chk("bp_first", y_0, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stable_y0", y_0, {24'd0, hold_y0});
      chk("bp_stable_valids", {y_valid_1, y_valid_0}, 32'h1);
      chk("bp_x_ready", {31'd0, x_ready}, 32'd0);
    end
    yr_force = 1'b1;
    step();
    chk("bp_still_first", {y_valid_1, y_valid_0}, 32'h1);
    step();
    chk("bp_second", {y_valid_1, y_valid_0, y_1}, {22'd0, 2'b10, 8'hC3});
    step();

    // Streaming: 8 pairs with alternating flag give 12 beats.
    cnt0 = split_cnt;
    beats0 = beats_seen;
    for (int i = 0; i < 8; i++)
      send_pair(8'(8'h30 + i), 8'(8'h80 + i), 4'(i), 4'(15 - i), 1'(i % 2));
    drain();
    chk("stream_beats", beats_seen - beats0, 32'd12);
    chk("stream_split_cnt", split_cnt, cnt0 + 4);

    // Random traffic with random downstream stalls.
    rand_yr = 1'b1;
    for (int i = 0; i < 150; i++)
      send_pair(8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    rand_yr = 1'b0;
    yr_force = 1'b1;
    drain();
    chk("rand_split_cnt", split_cnt, n_splits);
    exp_sat = (n_splits > 3) ? 3 : n_splits;
    chk("rand_sat_cnt", {30'd0, s_split_cnt}, exp_sat);

    // Saturation with a 2-bit counter, then reset in the middle of a split.
    do_reset();
    for (int i = 0; i < 5; i++)
      send_pair(8'(8'hE0 + i), 8'(8'hF0 + i), 4'd1, 4'd1, 1'b1);
    drain();
    chk("sat_cnt", {30'd0, s_split_cnt}, 32'd3);
    chk("wide_cnt", split_cnt, 32'd5);
    yr_force = 1'b0;
    step();
    send_pair(8'h77, 8'h88, 4'd2, 4'd2, 1'b1);
    chk("mid_split_x_ready", {31'd0, x_ready}, 32'd0);
    do_reset();
    yr_force = 1'b1;
    step();
    step();
    chk("after_rst_valids", {y_valid_1, y_valid_0}, 32'h0);
    chk("after_rst_x_ready", {30'd0, s_x_ready, x_ready}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
